// File: rtl/beta_mem_pkg.sv
// Shared types for the Beta memory arbiter: requester ids, FSM states and
// the access-latency counter width.
package beta_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ID_IF  = 2'd0,
    ID_DM  = 2'd1,
    ID_DBG = 2'd2
  } reqId_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arbState_t;

  // Counter load value: BUSY runs from lat-1 down to 0.
  function automatic logic [CNT_W-1:0] latToCnt(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/beta_rr_arb2.sv
// Two-way round-robin picker between instruction fetch and data ports.
// Purely combinational; debug priority is applied by the caller.
module beta_rr_arb2
  import beta_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic [1:0] last_grant,
  output logic [1:0] winner
);

  always_comb begin
    winner = ID_IF;
    if (if_req && dm_req) begin
      // On a tie the port that did not win last time goes next.
      winner = (last_grant == ID_IF) ? ID_DM : ID_IF;
    end else if (dm_req) begin
      winner = ID_DM;
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Single-port memory arbiter: IF / DM / DBG share one fixed-latency memory,
// one access at a time, with a one-cycle registered ack per completed access.
module beta_mem_arbiter
  import beta_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_CNT = latToCnt(MEM_LAT);

  arbState_t        state;
  logic [CNT_W-1:0] cnt;
  reqId_t           grantId;
  reqId_t           lastGrant;

  logic [1:0]    rrWinnerRaw;
  reqId_t        rrWinner;
  reqId_t        pickId;
  logic          anyReq;
  logic [AW-1:0] selAddr;
  logic          selWe;
  logic [DW-1:0] selWdata;

  beta_rr_arb2 u_rr (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .last_grant(lastGrant),
    .winner    (rrWinnerRaw)
  );

  assign rrWinner = reqId_t'(rrWinnerRaw);
  assign anyReq   = if_req | dm_req | dbg_req;
  assign pickId   = dbg_req ? ID_DBG : rrWinner;

  always_comb begin
    selAddr  = if_addr;
    selWe    = 1'b0;
    selWdata = '0;
    case (pickId)
      ID_DM: begin
        selAddr  = dm_addr;
        selWe    = dm_we;
        selWdata = dm_wdata;
      end
      ID_DBG: begin
        selAddr  = dbg_addr;
        selWe    = dbg_we;
        selWdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      grantId   <= ID_IF;
      lastGrant <= ID_IF;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      dbg_ack   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantId   <= pickId;
            // Debug grants do not disturb the CPU round-robin history.
            if (!dbg_req) lastGrant <= rrWinner;
            mem_en    <= 1'b1;
            mem_we    <= selWe;
            mem_addr  <= selAddr;
            mem_wdata <= selWdata;
            cnt       <= LAT_CNT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!mem_we) rdata <= mem_rdata;
            if_ack  <= (grantId == ID_IF);
            dm_ack  <= (grantId == ID_DM);
            dbg_ack <= (grantId == ID_DBG);
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK: begin
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
          dbg_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Scoreboard bench for beta_mem_arbiter: main instance at MEM_LAT=2 plus
// MEM_LAT=1 and MEM_LAT=15 instances sharing the same request inputs.
module tb_beta_mem_arbiter;
  import beta_mem_pkg::*;

  typedef struct packed {
    logic [1:0]  port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, dbg_addr = '0, dbg_wdata = '0;

  logic        ifAckV [3];
  logic        dmAckV [3];
  logic        dbgAckV[3];
  logic        stallV [3];
  logic        memEnV [3];
  logic        memWeV [3];
  logic [31:0] rdataV   [3];
  logic [31:0] memAddrV [3];
  logic [31:0] memWdataV[3];
  logic [31:0] memRdataV[3];

  int checks = 0;
  int failures = 0;
  exp_t sbQ[$];
  logic [31:0] expRd;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      assign memRdataV[gi] = memFn(memAddrV[gi]);
      beta_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT((gi == 0) ? 2 : ((gi == 1) ? 1 : 15))) u_dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (ifAckV[gi]),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dmAckV[gi]),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack  (dbgAckV[gi]),
        .rdata    (rdataV[gi]),
        .cpu_stall(stallV[gi]),
        .mem_en   (memEnV[gi]),
        .mem_we   (memWeV[gi]),
        .mem_addr (memAddrV[gi]),
        .mem_wdata(memWdataV[gi]),
        .mem_rdata(memRdataV[gi])
      );
    end
  endgenerate

  task automatic push_exp(input logic [1:0] p, input logic w, input logic [31:0] a,
                          input logic [31:0] wd);
    exp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = wd;
    if (!w) expRd = memFn(a);
    e.rdata = expRd;
    sbQ.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expRd = '0;
  endtask

  // Observes one access on the main instance; returns at the ack sample.
  task automatic collect(output logic [1:0] portSeen, output logic [31:0] addrSeen,
                         output logic weSeen, output logic [31:0] wdSeen, output int enCycles,
                         output logic stable, output int stallCnt, output logic stallAck,
                         output logic [31:0] rdSeen, output bit timedOut);
    int guard = 0;
    timedOut = 1'b0; enCycles = 0; stable = 1'b1; stallCnt = 0; portSeen = 2'd3;
    addrSeen = '0; weSeen = 1'b0; wdSeen = '0; stallAck = 1'b0; rdSeen = '0;
    @(negedge clk);
    while (!memEnV[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!memEnV[0]) begin
      timedOut = 1'b1;
      return;
    end
    addrSeen = memAddrV[0]; weSeen = memWeV[0]; wdSeen = memWdataV[0];
    while (memEnV[0] && enCycles < 40) begin
      enCycles++;
      if (memAddrV[0] !== addrSeen || memWeV[0] !== weSeen || memWdataV[0] !== wdSeen) stable = 1'b0;
      if (stallV[0]) stallCnt++;
      @(negedge clk);
    end
    case ({ifAckV[0], dmAckV[0], dbgAckV[0]})
      3'b100:  portSeen = ID_IF;
      3'b010:  portSeen = ID_DM;
      3'b001:  portSeen = ID_DBG;
      default: portSeen = 2'd3;
    endcase
    stallAck = stallV[0];
    rdSeen = rdataV[0];
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (memEnV[0] !== 1'b0 || memWeV[0] !== 1'b0) begin
      failures++; $display("FAIL reset_mem_ctl: got en=%b we=%b expected 0 0", memEnV[0], memWeV[0]);
    end
    checks++;
    if ({ifAckV[0], dmAckV[0], dbgAckV[0]} !== 3'b000) begin
      failures++; $display("FAIL reset_acks: got %b expected 000", {ifAckV[0], dmAckV[0], dbgAckV[0]});
    end
    checks++;
    if (rdataV[0] !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 00000000", rdataV[0]);
    end
    checks++;
    if (memAddrV[0] !== 32'h0 || memWdataV[0] !== 32'h0) begin
      failures++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0 0", memAddrV[0], memWdataV[0]);
    end
    checks++;
    if (stallV[0] !== 1'b0) begin
      failures++; $display("FAIL reset_stall: got %b expected 0", stallV[0]);
    end
  endtask

  task automatic test_single_read();
    logic [1:0] p; logic [31:0] a, wd, rd; logic w, st, sa; int en, sc; bit to; exp_t e;
    if_req = 1'b1; if_addr = 32'h40;
    push_exp(ID_IF, 1'b0, 32'h40, 32'h0);
    collect(p, a, w, wd, en, st, sc, sa, rd, to);
    e = sbQ.pop_front();
    if_req = 1'b0;
    checks++;
    if (to) begin failures++; $display("FAIL read_timeout: got no mem_en expected access"); end
    checks++;
    if (p !== e.port) begin failures++; $display("FAIL read_port: got %0d expected %0d", p, e.port); end
    checks++;
    if (a !== e.addr || w !== 1'b0) begin
      failures++; $display("FAIL read_bus: got addr=%h we=%b expected %h 0", a, w, e.addr);
    end
    checks++;
    if (en !== 2) begin failures++; $display("FAIL read_en_cycles: got %0d expected 2", en); end
    checks++;
    if (sc !== en) begin failures++; $display("FAIL read_stall_busy: got %0d expected %0d", sc, en); end
    checks++;
    if (sa !== 1'b0) begin failures++; $display("FAIL read_stall_ack: got %b expected 0", sa); end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL read_rdata: got %h expected %h", rd, e.rdata); end
    @(negedge clk);
    checks++;
    if ({ifAckV[0], dmAckV[0], dbgAckV[0]} !== 3'b000) begin
      failures++; $display("FAIL read_ack_pulse: got %b expected 000", {ifAckV[0], dmAckV[0], dbgAckV[0]});
    end
  endtask

  task automatic test_write();
    logic [1:0] p; logic [31:0] a, wd, rd; logic w, st, sa; int en, sc; bit to; exp_t e;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678;
    push_exp(ID_DM, 1'b1, 32'h100, 32'h12345678);
    collect(p, a, w, wd, en, st, sc, sa, rd, to);
    e = sbQ.pop_front();
    dm_req = 1'b0; dm_we = 1'b0;
    checks++;
    if (to || p !== e.port) begin failures++; $display("FAIL write_port: got %0d expected %0d", p, e.port); end
    checks++;
    if (a !== e.addr || w !== 1'b1 || wd !== e.wdata) begin
      failures++; $display("FAIL write_bus: got addr=%h we=%b wdata=%h expected %h 1 %h", a, w, wd, e.addr, e.wdata);
    end
    checks++;
    if (!st || en !== 2) begin failures++; $display("FAIL write_hold: got stable=%b cycles=%0d expected 1 2", st, en); end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL write_rdata_kept: got %h expected %h", rd, e.rdata); end
    @(negedge clk);
    checks++;
    if (dmAckV[0] !== 1'b0 || memWeV[0] !== 1'b0) begin
      failures++; $display("FAIL write_after: got ack=%b we=%b expected 0 0", dmAckV[0], memWeV[0]);
    end
  endtask

  task automatic test_contention();
    logic [1:0] p; logic [31:0] a, wd, rd; logic w, st, sa; int en, sc; bit to; exp_t e;
    do_reset();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    push_exp(ID_DM, 1'b0, 32'h300, 32'h0);
    push_exp(ID_IF, 1'b0, 32'h200, 32'h0);
    push_exp(ID_DM, 1'b0, 32'h300, 32'h0);
    push_exp(ID_IF, 1'b0, 32'h200, 32'h0);
    for (int g = 0; g < 4; g++) begin
      collect(p, a, w, wd, en, st, sc, sa, rd, to);
      e = sbQ.pop_front();
      checks++;
      if (to || p !== e.port || a !== e.addr) begin
        failures++; $display("FAIL contend_grant%0d: got port=%0d addr=%h expected %0d %h", g, p, a, e.port, e.addr);
      end
      checks++;
      if (sc !== en || en == 0) begin failures++; $display("FAIL contend_stall_busy%0d: got %0d expected %0d", g, sc, en); end
      // The other CPU port is still waiting, so stall stays high at the ack.
      checks++;
      if (sa !== 1'b1) begin failures++; $display("FAIL contend_stall_ack%0d: got %b expected 1", g, sa); end
      checks++;
      if (rd !== e.rdata) begin failures++; $display("FAIL contend_rdata%0d: got %h expected %h", g, rd, e.rdata); end
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dbg_priority();
    logic [1:0] p; logic [31:0] a, wd, rd; logic w, st, sa; int en, sc; bit to; exp_t e;
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h500; dbg_wdata = 32'hCAFEF00D;
    if_req = 1'b1; if_addr = 32'h600;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
    push_exp(ID_DBG, 1'b1, 32'h500, 32'hCAFEF00D);
    collect(p, a, w, wd, en, st, sc, sa, rd, to);
    e = sbQ.pop_front();
    dbg_req = 1'b0; dbg_we = 1'b0;
    checks++;
    if (to || p !== e.port) begin failures++; $display("FAIL dbg_first: got %0d expected %0d", p, e.port); end
    checks++;
    if (a !== e.addr || w !== 1'b1 || wd !== e.wdata) begin
      failures++; $display("FAIL dbg_bus: got addr=%h we=%b wdata=%h expected %h 1 %h", a, w, wd, e.addr, e.wdata);
    end
    checks++;
    if (sc !== en || sa !== 1'b1) begin
      failures++; $display("FAIL dbg_cpu_stall: got busy=%0d/%0d ack=%b expected all 1", sc, en, sa);
    end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL dbg_rdata_kept: got %h expected %h", rd, e.rdata); end
    push_exp(ID_DM, 1'b0, 32'h700, 32'h0);
    collect(p, a, w, wd, en, st, sc, sa, rd, to);
    e = sbQ.pop_front();
    if_req = 1'b0; dm_req = 1'b0;
    checks++;
    if (to || p !== e.port || a !== e.addr) begin
      failures++; $display("FAIL dbg_then_dm: got port=%0d addr=%h expected %0d %h", p, a, e.port, e.addr);
    end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL dbg_then_dm_rdata: got %h expected %h", rd, e.rdata); end
    @(negedge clk);
    dbg_req = 1'b1; dbg_addr = 32'h44;
    push_exp(ID_DBG, 1'b0, 32'h44, 32'h0);
    collect(p, a, w, wd, en, st, sc, sa, rd, to);
    e = sbQ.pop_front();
    dbg_req = 1'b0;
    checks++;
    if (to || p !== e.port || sc !== 0) begin
      failures++; $display("FAIL dbg_no_stall: got port=%0d stall_cycles=%0d expected %0d 0", p, sc, e.port);
    end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL dbg_read_rdata: got %h expected %h", rd, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    logic [1:0] p; logic [31:0] a, wd, rd; logic w, st, sa; int en, sc; bit to; exp_t e;
    int guard = 0;
    if_req = 1'b1; if_addr = 32'h84;
    @(negedge clk);
    while (!memEnV[0] && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (memEnV[0] !== 1'b1) begin failures++; $display("FAIL midrst_start: got en=%b expected 1", memEnV[0]); end
    reset = 1'b1;
    #1;
    checks++;
    if (memEnV[0] !== 1'b0 || memWeV[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_async: got en=%b we=%b expected 0 0", memEnV[0], memWeV[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ifAckV[0], dmAckV[0], dbgAckV[0]} !== 3'b000) begin
        failures++; $display("FAIL midrst_no_ack%0d: got %b expected 000", i, {ifAckV[0], dmAckV[0], dbgAckV[0]});
      end
    end
    reset = 1'b0;
    expRd = '0;
    push_exp(ID_IF, 1'b0, 32'h84, 32'h0);
    collect(p, a, w, wd, en, st, sc, sa, rd, to);
    e = sbQ.pop_front();
    if_req = 1'b0;
    checks++;
    if (to || p !== e.port || en !== 2) begin
      failures++; $display("FAIL midrst_recover: got port=%0d cycles=%0d expected %0d 2", p, en, e.port);
    end
    checks++;
    if (rd !== e.rdata) begin failures++; $display("FAIL midrst_rdata: got %h expected %h", rd, e.rdata); end
    @(negedge clk);
  endtask

  task automatic test_lat_sweep();
    int grantN[3]; int ackN[3]; int enCnt[3]; bit got[3]; bit acked[3]; logic [31:0] rdS[3];
    do_reset();
    for (int d = 0; d < 3; d++) begin
      grantN[d] = 0; ackN[d] = 0; enCnt[d] = 0; got[d] = 0; acked[d] = 0; rdS[d] = '0;
    end
    if_req = 1'b1; if_addr = 32'h88;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!got[d] && memEnV[d]) begin got[d] = 1'b1; grantN[d] = n; end
        if (got[d] && !acked[d] && memEnV[d]) enCnt[d]++;
        if (got[d] && !acked[d] && ifAckV[d]) begin acked[d] = 1'b1; ackN[d] = n; rdS[d] = rdataV[d]; end
      end
    end
    if_req = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (!acked[d]) begin failures++; $display("FAIL sweep_ack_lat%0d: got no ack expected one", latOf(d)); end
      checks++;
      if (ackN[d] - grantN[d] + 1 !== latOf(d) + 1) begin
        failures++; $display("FAIL sweep_latency_lat%0d: got %0d expected %0d", latOf(d), ackN[d] - grantN[d] + 1, latOf(d) + 1);
      end
      checks++;
      if (enCnt[d] !== latOf(d)) begin
        failures++; $display("FAIL sweep_en_lat%0d: got %0d expected %0d", latOf(d), enCnt[d], latOf(d));
      end
      checks++;
      if (rdS[d] !== memFn(32'h88)) begin
        failures++; $display("FAIL sweep_rdata_lat%0d: got %h expected %h", latOf(d), rdS[d], memFn(32'h88));
      end
    end
    do_reset();
  endtask

  initial begin
    expRd = '0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_dbg_priority();
    test_reset_mid_busy();
    test_lat_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
